// File: rtl/oculink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oculink_pkg
// Description : Shared types and helpers for Oculink per-port controllers.
//               - state encodings for the PERST# sequencer (3-bit)
//               - retry counter width
//               - counter width helper sized from a set of cycle limits
// Revision    : 1.0 - initial release
// ============================================================================
package oculink_pkg;

  localparam logic [2:0] IDLE_ENC     = 3'd0;
  localparam logic [2:0] DEBOUNCE_ENC = 3'd1;
  localparam logic [2:0] SETTLE_ENC   = 3'd2;
  localparam logic [2:0] TRAIN_ENC    = 3'd3;
  localparam logic [2:0] UP_ENC       = 3'd4;
  localparam logic [2:0] FAIL_ENC     = 3'd5;

  localparam int RETRY_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = IDLE_ENC,
    ST_DEBOUNCE = DEBOUNCE_ENC,
    ST_SETTLE   = SETTLE_ENC,
    ST_TRAIN    = TRAIN_ENC,
    ST_UP       = UP_ENC,
    ST_FAIL     = FAIL_ENC
  } perst_state_e;

  // A state with limit L counts 0..L-1, so $clog2(L) bits hold the largest
  // value reached. At least one bit is kept for degenerate limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage
`default_nettype wire

// File: rtl/oculink_sync2.sv
`default_nettype none
// ============================================================================
// Module      : oculink_sync2
// Description : Two-flop synchronizer, asynchronous active-high reset.
//   clk_i  : destination clock
//   rst_i  : asynchronous reset, active high
//   d_i    : asynchronous input
//   q_o    : synchronized output (two destination-clock cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module oculink_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/oculink_perst_seq.sv
`default_nettype none
// ============================================================================
// Module      : oculink_perst_seq
// Description : Per-port PERST#/bring-up sequencer for an Oculink root port.
//               Debounces cable-present, holds PERST# for the power-settle
//               time, releases it and waits for link-up with a timeout,
//               retrying a bounded number of times before latching FAIL.
//   sys_clk_i    : free-running system clock (not from the PCIe core)
//   sys_rst_i    : asynchronous reset, active high
//   enable_i     : software enable
//   retry_clr_i  : single-cycle pulse, leaves FAIL
//   cprsnt_n_i   : cable present, active low, asynchronous
//   link_up_i    : link-up from the PCIe core, asynchronous
//   perst_n_o    : registered PERST# to the pad
//   link_ready_o : high while in UP
//   fail_o       : high while in FAIL
//   state_o      : current state encoding
//   retry_cnt_o  : failed attempts in the current bring-up
// Revision    : 1.0 - initial release
// ============================================================================
module oculink_perst_seq
  import oculink_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = 250000,
  parameter int PWR_SETTLE_CYC   = 25000000,
  parameter int LINK_TIMEOUT_CYC = 25000000,
  parameter int MAX_RETRY        = 3
) (
  input  logic               sys_clk_i,
  input  logic               sys_rst_i,
  input  logic               enable_i,
  input  logic               retry_clr_i,
  input  logic               cprsnt_n_i,
  input  logic               link_up_i,
  output logic               perst_n_o,
  output logic               link_ready_o,
  output logic               fail_o,
  output logic [2:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYC, PWR_SETTLE_CYC, LINK_TIMEOUT_CYC);

  localparam logic [CNT_W-1:0]   c_DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0]   c_SETTLE_LAST = CNT_W'(PWR_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   c_TRAIN_LAST  = CNT_W'(LINK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] c_MAX_RETRY   = RETRY_W'(MAX_RETRY);

  logic present;
  logic link_sync;

  // Present is inverted ahead of the synchronizer so that the flop reset
  // value of 0 means "not present".
  oculink_sync2 #(.RST_VAL(1'b0)) u_sync_present (
    .clk_i (sys_clk_i),
    .rst_i (sys_rst_i),
    .d_i   (~cprsnt_n_i),
    .q_o   (present)
  );

  oculink_sync2 #(.RST_VAL(1'b0)) u_sync_link (
    .clk_i (sys_clk_i),
    .rst_i (sys_rst_i),
    .d_i   (link_up_i),
    .q_o   (link_sync)
  );

  perst_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               perst_n_q, link_ready_q, fail_q;
  logic               counting;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = retry_q + RETRY_W'(1);
    if (!present || !enable_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:     state_d = ST_DEBOUNCE;
        ST_DEBOUNCE: if (cnt_q == c_DEB_LAST) state_d = ST_SETTLE;
        ST_SETTLE:   if (cnt_q == c_SETTLE_LAST) state_d = ST_TRAIN;
        ST_TRAIN: begin
          // link-up takes precedence over a coincident timeout
          if (link_sync) begin
            state_d = ST_UP;
          end else if (cnt_q == c_TRAIN_LAST) begin
            retry_d = retry_inc;
            state_d = (retry_inc == c_MAX_RETRY) ? ST_FAIL : ST_SETTLE;
          end
        end
        ST_UP:       if (!link_sync) state_d = ST_SETTLE;
        ST_FAIL:     if (retry_clr_i) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_IDLE || state_d == ST_UP) begin
      retry_d = '0;
    end
  end

  assign counting = (state_q == ST_DEBOUNCE) || (state_q == ST_SETTLE) ||
                    (state_q == ST_TRAIN);

  // Outputs are loaded from the next state so they switch together with
  // the state register.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      perst_n_q    <= 1'b0;
      link_ready_q <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (counting) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      perst_n_q    <= (state_d == ST_TRAIN) || (state_d == ST_UP);
      link_ready_q <= (state_d == ST_UP);
      fail_q       <= (state_d == ST_FAIL);
    end
  end

  assign perst_n_o    = perst_n_q;
  assign link_ready_o = link_ready_q;
  assign fail_o       = fail_q;
  assign state_o      = state_q;
  assign retry_cnt_o  = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_oculink_perst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_oculink_perst_seq
// Description : Self-checking bench for oculink_perst_seq. A behavioural
//               phase/elapsed-time model tracks expected outputs each cycle;
//               a vector table and short hand sequences pin down the
//               boundary timings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oculink_perst_seq;

  localparam int DEB  = 4;
  localparam int PWR  = 10;
  localparam int LTO  = 20;
  localparam int MAXR = 2;

  localparam int P_IDLE = 0, P_DEB = 1, P_SET = 2, P_TRN = 3, P_UP = 4, P_FAIL = 5;

  logic       clk = 1'b0;
  logic       rst, en, cprsnt_n, link, clr;
  logic       perst_n, ready, fail;
  logic [2:0] st, rc;

  always #5 clk = ~clk;

  oculink_perst_seq #(
    .DEBOUNCE_CYC     (DEB),
    .PWR_SETTLE_CYC   (PWR),
    .LINK_TIMEOUT_CYC (LTO),
    .MAX_RETRY        (MAXR)
  ) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .enable_i     (en),
    .retry_clr_i  (clr),
    .cprsnt_n_i   (cprsnt_n),
    .link_up_i    (link),
    .perst_n_o    (perst_n),
    .link_ready_o (ready),
    .fail_o       (fail),
    .state_o      (st),
    .retry_cnt_o  (rc)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  int     m_phase, m_elapsed, m_fails;
  bit [1:0] m_pres, m_link;   // [0] newest pad sample, [1] what the sequencer sees

  task automatic model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_fails = 0; m_pres = 2'b00; m_link = 2'b00;
  endtask

  task automatic model_edge();
    bit pres_seen, link_seen;
    int nxt;
    pres_seen = m_pres[1];
    link_seen = m_link[1];
    nxt = m_phase;
    if (!pres_seen || !en) nxt = P_IDLE;
    else begin
      case (m_phase)
        P_IDLE: nxt = P_DEB;
        P_DEB:  if (m_elapsed + 1 >= DEB) nxt = P_SET;
        P_SET:  if (m_elapsed + 1 >= PWR) nxt = P_TRN;
        P_TRN: begin
          if (link_seen) nxt = P_UP;
          else if (m_elapsed + 1 >= LTO) begin
            m_fails = m_fails + 1;
            nxt = (m_fails >= MAXR) ? P_FAIL : P_SET;
          end
        end
        P_UP:   if (!link_seen) nxt = P_SET;
        P_FAIL: if (clr) nxt = P_IDLE;
        default: nxt = P_IDLE;
      endcase
    end
    if (nxt == P_IDLE || nxt == P_UP) m_fails = 0;
    m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
    m_phase = nxt;
    m_pres = {m_pres[0], ~cprsnt_n};
    m_link = {m_link[0], link};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int es, input bit ep, input bit er,
                       input bit ef, input int erc);
    n_vec++;
    if (st !== 3'(es) || perst_n !== ep || ready !== er || fail !== ef || rc !== 3'(erc)) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s @%0t: got state=%0d perst_n=%b link_ready=%b fail=%b retry_cnt=%0d, want state=%0d perst_n=%b link_ready=%b fail=%b retry_cnt=%0d",
                 name, $time, st, perst_n, ready, fail, rc, es, ep, er, ef, erc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model", m_phase, (m_phase == P_TRN) || (m_phase == P_UP),
          m_phase == P_UP, m_phase == P_FAIL, m_fails);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int n; bit e; bit cp; bit lk; bit cl;
    int s; bit p; bit r; bit f; int rcnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input bit e, input bit cp, input bit lk, input bit cl,
                     input int s, input bit p, input bit r, input bit f, input int rcnt);
    vec_t v;
    v.n = n; v.e = e; v.cp = cp; v.lk = lk; v.cl = cl;
    v.s = s; v.p = p; v.r = r; v.f = f; v.rcnt = rcnt;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cprsnt_n = 1'b1; link = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", P_IDLE, 0, 0, 0, 0);
    rst = 1'b0;

    //   n  en cp lk cl  state  perst rdy fail retry
    // nominal bring-up: PERST# release 17 cycles after plug-in
    add(16, 1, 0, 0, 0, P_SET,  0, 0, 0, 0);
    add( 1, 1, 0, 0, 0, P_TRN,  1, 0, 0, 0);
    add( 4, 1, 0, 0, 0, P_TRN,  1, 0, 0, 0);
    // link-up pad to link_ready: 3 cycles
    add( 2, 1, 0, 1, 0, P_TRN,  1, 0, 0, 0);
    add( 1, 1, 0, 1, 0, P_UP,   1, 1, 0, 0);
    // link loss: PERST# falls after 3 cycles, held 10
    add( 2, 1, 0, 0, 0, P_UP,   1, 1, 0, 0);
    add( 1, 1, 0, 0, 0, P_SET,  0, 0, 0, 0);
    add( 9, 1, 0, 0, 0, P_SET,  0, 0, 0, 0);
    add( 1, 1, 0, 0, 0, P_TRN,  1, 0, 0, 0);
    // timeouts into FAIL
    add(19, 1, 0, 0, 0, P_TRN,  1, 0, 0, 0);
    add( 1, 1, 0, 0, 0, P_SET,  0, 0, 0, 1);
    add( 9, 1, 0, 0, 0, P_SET,  0, 0, 0, 1);
    add( 1, 1, 0, 0, 0, P_TRN,  1, 0, 0, 1);
    add(19, 1, 0, 0, 0, P_TRN,  1, 0, 0, 1);
    add( 1, 1, 0, 0, 0, P_FAIL, 0, 0, 1, 2);
    add( 5, 1, 0, 0, 0, P_FAIL, 0, 0, 1, 2);
    // retry_clr returns to IDLE, then re-sequences
    add( 1, 1, 0, 0, 1, P_IDLE, 0, 0, 0, 0);
    add( 1, 1, 0, 0, 0, P_DEB,  0, 0, 0, 0);
    add( 3, 1, 0, 0, 0, P_DEB,  0, 0, 0, 0);
    add( 1, 1, 0, 0, 0, P_SET,  0, 0, 0, 0);
    add(10, 1, 0, 0, 0, P_TRN,  1, 0, 0, 0);
    // link-up seen exactly at the timeout cycle
    add(17, 1, 0, 0, 0, P_TRN,  1, 0, 0, 0);
    add( 2, 1, 0, 1, 0, P_TRN,  1, 0, 0, 0);
    add( 1, 1, 0, 1, 0, P_UP,   1, 1, 0, 0);
    // hot unplug from UP
    add( 2, 1, 1, 1, 0, P_UP,   1, 1, 0, 0);
    add( 1, 1, 1, 1, 0, P_IDLE, 0, 0, 0, 0);
    add( 3, 1, 1, 0, 0, P_IDLE, 0, 0, 0, 0);
    // enable gating
    add( 5, 0, 0, 0, 0, P_IDLE, 0, 0, 0, 0);
    add( 1, 1, 0, 0, 0, P_DEB,  0, 0, 0, 0);
    add( 1, 0, 0, 0, 0, P_IDLE, 0, 0, 0, 0);
    add( 3, 1, 1, 0, 0, P_IDLE, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].e; cprsnt_n = tbl[i].cp; link = tbl[i].lk; clr = tbl[i].cl;
      repeat (tbl[i].n) tick();
      check($sformatf("tbl%0d", i), tbl[i].s, tbl[i].p, tbl[i].r, tbl[i].f, tbl[i].rcnt);
    end

    // bounce: 3 cycles present, 1 absent, repeated
    en = 1'b1; link = 1'b0; clr = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4; c++) begin
        cprsnt_n = (c == 3);
        tick();
        n_vec++;
        if (perst_n !== 1'b0 || st > 3'd1) begin
          n_bad++;
          $display("FAIL bounce: got state=%0d perst_n=%b, want state<=1 perst_n=0", st, perst_n);
        end
      end
    end

    // asynchronous reset during SETTLE
    cprsnt_n = 1'b1;
    repeat (3) tick();
    cprsnt_n = 1'b0;
    repeat (9) tick();
    check("pre_rst_settle", P_SET, 0, 0, 0, 0);
    #2 rst = 1'b1; model_reset();
    #1 check("rst_settle", P_IDLE, 0, 0, 0, 0);
    #3 rst = 1'b0;

    // asynchronous reset during TRAIN drops PERST# without a clock edge
    repeat (17) tick();
    check("pre_rst_train", P_TRN, 1, 0, 0, 0);
    #2 rst = 1'b1; model_reset();
    #1 check("rst_train", P_IDLE, 0, 0, 0, 0);
    #3 rst = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int lrate;
      lrate = ((i / 500) % 3 == 0) ? 7 : (((i / 500) % 3 == 1) ? 39 : 199);
      if ($urandom_range(59) == 0) cprsnt_n = ~cprsnt_n;
      if ($urandom_range(lrate) == 0) link = ~link;
      if ($urandom_range(299) == 0) en = ~en;
      clr = ($urandom_range(19) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oculink_perst_seq.md
# oculink_perst_seq

Per-port PERST#/bring-up sequencer for an Oculink PCIe root port. It watches the cable-present pin and a software enable. Once the cable has debounced, it holds PERST# asserted for the power-settle interval, then releases it and waits for link-up with a timeout. It retries a bounded number of times before latching a failure. One instance sits beside each Oculink port instance and drives that port's `perst_n` pad.

## Interface
- `DEBOUNCE_CYC`, 250000: cycles cable-present must be stably asserted before sequencing starts.
- `PWR_SETTLE_CYC`, 25000000: PERST# hold time (T_PVPERL) before release.
- `LINK_TIMEOUT_CYC`, 25000000: max cycles waiting for link-up after release.
- `MAX_RETRY`, 3: failed training attempts before entering FAIL (1..7).
- `sys_clk` input 1: free-running system clock. It must not be derived from the PCIe core clock.
- `sys_rst` input 1: asynchronous, active-high reset.
- `enable` input 1: software enable, `sys_clk` domain.
- `retry_clr` input 1: single-cycle pulse that leaves FAIL.
- `cprsnt_n` input 1: cable present, active-low, asynchronous.
- `link_up` input 1: link-up from the PCIe core, asynchronous to `sys_clk`.
- `perst_n` output 1: registered PERST# to the pad.
- `link_ready` output 1: high while in UP.
- `fail` output 1: high while in FAIL.
- `state` output 3: current FSM state encoding.
- `retry_cnt` output 3: failed attempts in the current bring-up.

## Operation
- Synchronization:
  - `cprsnt_n` and `link_up` each pass through a 2-flop synchronizer.
  - `present` = inverted, synchronized `cprsnt_n`.
  - All FSM decisions use the synchronized values.
- Counter: one shared counter `cnt`, cleared on every state transition. A state with limit L exits when `cnt == L-1`, so it lasts exactly L cycles.
- States and encodings: IDLE=0, DEBOUNCE=1, SETTLE=2, TRAIN=3, UP=4, FAIL=5.
- Global abort: in any state, `!present || !enable` forces IDLE on the next cycle. This has the highest priority.
- IDLE → DEBOUNCE when `present && enable`. `retry_cnt` clears on entry to IDLE.
- DEBOUNCE → SETTLE after `DEBOUNCE_CYC` consecutive present cycles. A drop of `present` aborts to IDLE (global rule).
- SETTLE → TRAIN after `PWR_SETTLE_CYC` cycles.
- TRAIN exits:
  - If synchronized `link_up` is high, go to UP.
  - Else at `cnt == LINK_TIMEOUT_CYC-1`, increment `retry_cnt`. Go to FAIL if the incremented value equals `MAX_RETRY`, otherwise go to SETTLE.
  - If `link_up` and timeout occur in the same cycle, `link_up` wins.
- UP: entry clears `retry_cnt`. Loss of `link_up` goes to SETTLE; PERST# is re-asserted for the full settle time. This is not counted as a retry.
- FAIL: hold until `retry_clr`, then go to IDLE. `retry_clr` in any other state is ignored.
- `perst_n` is high only in TRAIN and UP. It is a register loaded from next-state, so it changes in the same cycle the state register does. Every PERST# assertion lasts at least `PWR_SETTLE_CYC`, except an abort into IDLE, which holds PERST# until re-sequenced.

## Timing
- Reset values:
  - `state` = IDLE
  - `perst_n` = 0
  - `link_ready` = 0
  - `fail` = 0
  - `retry_cnt` = 0
  - `cnt` = 0
  - synchronizer flops = 0 (0 means not present / link down)
- Pad-to-FSM latency is 2 cycles. From an IDLE sample of `present` to `perst_n` rising is 1 + `DEBOUNCE_CYC` + `PWR_SETTLE_CYC` cycles.
- `link_up` pad rising to `link_ready` rising takes 3 cycles (2 sync + 1 register).
- Removal to `perst_n` falling takes 3 cycles.
- `sys_rst` mid-sequence asynchronously forces `perst_n` low immediately.
- `cnt` width is `$clog2` of the largest limit. The counter does not wrap, because every state that counts exits at its limit.

## Structure
- Package `oculink_pkg` holds:
  - state encoding localparams (IDLE..FAIL, 3-bit)
  - `RETRY_W = 3`
  - the `CNT_W` calculation function, shared with other per-port controllers
- Sub-module `oculink_sync2` is a 2-flop synchronizer with async active-high reset and a reset value parameter. It is instantiated twice. Its flops are marked ASYNC_REG.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYC`=4, `PWR_SETTLE_CYC`=10, `LINK_TIMEOUT_CYC`=20, `MAX_RETRY`=2.
- Nominal bring-up: `enable`=1, then drive `cprsnt_n` low at cycle 0.
  - `perst_n` rises at cycle 17 (2 sync + 1 + 4 + 10).
  - `link_up` asserted 5 cycles later gives `link_ready` 3 cycles after that, with `retry_cnt`=0.
- Bounce: toggle `cprsnt_n` low for 3 cycles, high for 1, repeated.
  - FSM never leaves IDLE/DEBOUNCE and `perst_n` stays 0.
- Retry to FAIL: cable present, `link_up` held 0.
  - Sequence is TRAIN for 20 cycles, SETTLE for 10, TRAIN for 20, then FAIL.
  - `retry_cnt`=2, `fail`=1, `perst_n`=0.
  - `retry_clr` returns to IDLE, then re-sequences because the cable is still present.
- Simultaneous events: `link_up` arrives synchronized exactly at `cnt`=19 in TRAIN.
  - Result is UP and `retry_cnt` unchanged.
- Link loss: drop `link_up` while in UP.
  - `perst_n` falls 3 cycles later and stays low 10 cycles.
  - `retry_cnt` is not incremented.
- Hot unplug: in UP, raise `cprsnt_n`.
  - State goes to IDLE and `perst_n` = 0 within 3 cycles.
  - Asserting `sys_rst` during SETTLE gives all outputs at their reset values asynchronously.
